// File: rtl/ras_ckpt.sv
// ras_ckpt: return address stack with checkpoint/restore; RAS_STATS_EN adds overflow/underflow counters
module ras_ckpt #(
    parameter int XLEN = 32,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push_en,
    input  logic [XLEN-1:0]  push_addr,
    input  logic             pop_en,
    input  logic             restore_en,
    input  logic [PTR_W-1:0] restore_ptr,
    input  logic [CNT_W-1:0] restore_cnt,
    input  logic [XLEN-1:0]  restore_top,
    output logic [XLEN-1:0]  top_addr,
    output logic             valid,
    output logic [PTR_W-1:0] ckpt_ptr,
    output logic [CNT_W-1:0] ckpt_cnt,
    output logic [XLEN-1:0]  ckpt_top,
    output logic [15:0]      stat_ovf_cnt,
    output logic [15:0]      stat_udf_cnt
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [XLEN-1:0]  stack [DEPTH];
    logic [PTR_W-1:0] tos, tos_nxt, wr_idx;
    logic [CNT_W-1:0] count, cnt_nxt;
    logic [XLEN-1:0]  wr_data;
    logic             wr_en, push_only, pop_only, both, empty, full;

    assign push_only = push_en & ~pop_en;
    assign pop_only  = pop_en & ~push_en;
    assign both      = push_en & pop_en;
    assign empty     = count == '0;
    assign full      = count == FULL;

    assign top_addr = stack[tos];
    assign ckpt_top = top_addr;
    assign ckpt_ptr = tos;
    assign ckpt_cnt = count;
    assign valid    = ~empty;

    // next pointer/count and the single entry write, in priority flush > restore > push/pop
    always_comb begin
        tos_nxt = tos;
        cnt_nxt = count;
        wr_en   = 1'b0;
        wr_idx  = tos;
        wr_data = push_addr;
        if (flush) begin
            tos_nxt = '0;
            cnt_nxt = '0;
        end else if (restore_en) begin
            tos_nxt = restore_ptr;
            cnt_nxt = restore_cnt > FULL ? FULL : restore_cnt;
            wr_en   = 1'b1;
            wr_idx  = restore_ptr;
            wr_data = restore_top;
        end else if (push_only) begin
            tos_nxt = tos + 1'b1;
            cnt_nxt = full ? count : count + 1'b1;
            wr_en   = 1'b1;
            wr_idx  = tos + 1'b1;
        end else if (pop_only && !empty) begin
            tos_nxt = tos - 1'b1;
            cnt_nxt = count - 1'b1;
        end else if (both) begin
            wr_en   = 1'b1;
            cnt_nxt = empty ? CNT_W'(1) : count;
        end
    end

    // stack state register; reset clears every entry
    always_ff @(posedge clk) begin
        if (reset) begin
            tos   <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
        end else begin
            tos   <= tos_nxt;
            count <= cnt_nxt;
            if (wr_en) stack[wr_idx] <= wr_data;
        end
    end

`ifdef RAS_STATS_EN
    logic        ovf_ev, udf_ev;
    logic [15:0] ovf_q, udf_q;

    assign ovf_ev = ~flush & ~restore_en & push_only & full;
    assign udf_ev = ~flush & ~restore_en & pop_only & empty;
    assign stat_ovf_cnt = ovf_q;
    assign stat_udf_cnt = udf_q;

    // saturating event counters, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= '0;
            udf_q <= '0;
        end else begin
            if (ovf_ev && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 1'b1;
            if (udf_ev && udf_q != 16'hFFFF) udf_q <= udf_q + 1'b1;
        end
    end
`else
    assign stat_ovf_cnt = '0;
    assign stat_udf_cnt = '0;
`endif
endmodule
